// File: rtl/branch_predictor_table.sv
// ----------------------------------------------------------------------------
// branch_predictor_table
//
// PC-indexed branch history table of CTR_BITS-wide saturating counters, with
// optional gshare indexing through a non-speculative global history register.
// The IF side gets a combinational prediction and predicted next PC. The EX side
// trains the table and the GHR, and raises a redirect on a mispredict. The
// table index used by IF travels down the pipeline (EX_index), so each update
// lands on the entry that made the prediction.
//
// Ports
//   clk               clock
//   reset             synchronous, active-low reset
//   IF_opcode         opcode of the fetched instruction
//   IF_pc             fetch PC
//   IF_imm            branch immediate of the fetched instruction
//   EX_branch         EX holds a resolved conditional branch this cycle
//   EX_branch_taken   actual branch outcome
//   EX_prediction     branch_estimation carried from IF
//   EX_index          predict_index carried from IF
//   EX_pc             PC of the EX branch
//   EX_imm            immediate of the EX branch
//   branch_estimation predicted taken
//   branch_target     predicted next PC
//   predict_index     table index used for the IF prediction
//   mispredict        EX mispredict; flush IF/ID
//   redirect_pc       corrected PC (always driven, meaningful when mispredict=1)
//   branch_count      resolved branches (saturating)
//   mispredict_count  mispredicted branches (saturating)
// ----------------------------------------------------------------------------
module branch_predictor_table #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned GHR_BITS   = 0,
    parameter int unsigned STAT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            IF_opcode,
    input  logic [XLEN-1:0]       IF_pc,
    input  logic [XLEN-1:0]       IF_imm,
    input  logic                  EX_branch,
    input  logic                  EX_branch_taken,
    input  logic                  EX_prediction,
    input  logic [INDEX_BITS-1:0] EX_index,
    input  logic [XLEN-1:0]       EX_pc,
    input  logic [XLEN-1:0]       EX_imm,
    output logic                  branch_estimation,
    output logic [XLEN-1:0]       branch_target,
    output logic [INDEX_BITS-1:0] predict_index,
    output logic                  mispredict,
    output logic [XLEN-1:0]       redirect_pc,
    output logic [STAT_BITS-1:0]  branch_count,
    output logic [STAT_BITS-1:0]  mispredict_count
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    localparam logic [6:0]           OPCODE_BRANCH = 7'b1100011;
    localparam logic [CTR_BITS-1:0]  CTR_MAX       = '1;
    // Weakly-not-taken: 01 for 2-bit counters, 0 for 1-bit counters.
    localparam logic [CTR_BITS-1:0]  CTR_INIT      = CTR_MAX >> 1;
    localparam logic [CTR_BITS-1:0]  CTR_ONE       = CTR_BITS'(1);
    localparam logic [STAT_BITS-1:0] STAT_ONE      = STAT_BITS'(1);
    localparam logic [XLEN-1:0]      PC_STEP       = XLEN'(4);

    logic [CTR_BITS-1:0]   bht [ENTRIES];
    logic [INDEX_BITS-1:0] pc_index;
    logic [INDEX_BITS-1:0] ghr_index;

    // Word-aligned PC bits select the entry; byte-offset and high PC bits are
    // intentionally not part of the index.
    assign pc_index = IF_pc[INDEX_BITS+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_pc[XLEN-1:INDEX_BITS+2], IF_pc[1:0]};

    // ------------------------------------------------------------------
    // Global history (present only for gshare configurations)
    // ------------------------------------------------------------------
    generate
        if (GHR_BITS > 0) begin : g_ghr
            logic [GHR_BITS-1:0] ghr;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    ghr <= '0;
                end else if (EX_branch) begin
                    // Truncating cast keeps the low GHR_BITS of {ghr, outcome},
                    // i.e. shift left and insert the new outcome; also valid
                    // for a 1-bit history.
                    ghr <= GHR_BITS'({ghr, EX_branch_taken});
                end
            end

            assign ghr_index = INDEX_BITS'(ghr);
        end else begin : g_no_ghr
            assign ghr_index = '0;
        end
    endgenerate

    assign predict_index = pc_index ^ ghr_index;

    // ------------------------------------------------------------------
    // Counter table. Reads are asynchronous; a same-cycle EX write to the
    // entry being read is not bypassed, so IF sees the pre-update value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bht[INDEX_BITS'(i)] <= CTR_INIT;
            end
        end else if (EX_branch) begin
            if (EX_branch_taken) begin
                if (bht[EX_index] != CTR_MAX) begin
                    bht[EX_index] <= bht[EX_index] + CTR_ONE;
                end
            end else begin
                if (bht[EX_index] != '0) begin
                    bht[EX_index] <= bht[EX_index] - CTR_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // IF-side prediction
    // ------------------------------------------------------------------
    always_comb begin
        branch_estimation = 1'b0;
        if (IF_opcode == OPCODE_BRANCH) begin
            branch_estimation = bht[predict_index][CTR_BITS-1];
        end
        branch_target = IF_pc + (branch_estimation ? IF_imm : PC_STEP);
    end

    // ------------------------------------------------------------------
    // EX-side resolution
    // ------------------------------------------------------------------
    always_comb begin
        mispredict  = EX_branch && (EX_prediction != EX_branch_taken);
        redirect_pc = EX_pc + (EX_branch_taken ? EX_imm : PC_STEP);
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (EX_branch && (branch_count != '1)) begin
                branch_count <= branch_count + STAT_ONE;
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + STAT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_table.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor_table
//
// Two instances share one stimulus stream: dut_a is the default bimodal
// configuration, dut_b uses a 4-bit GHR and 4-bit statistics counters.
// Expected values are queued when stimulus is applied and compared against
// sampled outputs at the end of each scenario task.
// ----------------------------------------------------------------------------
module tb_branch_predictor_table;

    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ALU = 7'b0010011;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [6:0]  IF_opcode;
    logic [31:0] IF_pc, IF_imm;
    logic        EX_branch, EX_branch_taken, EX_prediction;
    logic [5:0]  EX_index;
    logic [31:0] EX_pc, EX_imm;

    logic        est_a, mis_a;
    logic [31:0] tgt_a, rpc_a, bc_a, mc_a;
    logic [5:0]  idx_a;

    logic        est_b, mis_b;
    logic [31:0] tgt_b, rpc_b;
    logic [5:0]  idx_b;
    logic [3:0]  bc_b, mc_b;

    int checks = 0;
    int errors = 0;

    string       sb_name[$];
    logic [63:0] sb_exp[$];
    logic [63:0] obs[$];

    branch_predictor_table dut_a (
        .clk(clk), .reset(reset),
        .IF_opcode(IF_opcode), .IF_pc(IF_pc), .IF_imm(IF_imm),
        .EX_branch(EX_branch), .EX_branch_taken(EX_branch_taken),
        .EX_prediction(EX_prediction), .EX_index(EX_index),
        .EX_pc(EX_pc), .EX_imm(EX_imm),
        .branch_estimation(est_a), .branch_target(tgt_a),
        .predict_index(idx_a), .mispredict(mis_a), .redirect_pc(rpc_a),
        .branch_count(bc_a), .mispredict_count(mc_a)
    );

    branch_predictor_table #(.GHR_BITS(4), .STAT_BITS(4)) dut_b (
        .clk(clk), .reset(reset),
        .IF_opcode(IF_opcode), .IF_pc(IF_pc), .IF_imm(IF_imm),
        .EX_branch(EX_branch), .EX_branch_taken(EX_branch_taken),
        .EX_prediction(EX_prediction), .EX_index(EX_index),
        .EX_pc(EX_pc), .EX_imm(EX_imm),
        .branch_estimation(est_b), .branch_target(tgt_b),
        .predict_index(idx_b), .mispredict(mis_b), .redirect_pc(rpc_b),
        .branch_count(bc_b), .mispredict_count(mc_b)
    );

    task automatic push_exp(input string name, input logic [63:0] value);
        sb_name.push_back(name);
        sb_exp.push_back(value);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        EX_branch = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // One resolved branch in EX for a single clock edge.
    task automatic ex_cycle(input logic [5:0] idx, input logic taken, input logic pred);
        @(negedge clk);
        EX_branch = 1'b1;
        EX_index = idx;
        EX_branch_taken = taken;
        EX_prediction = pred;
        @(posedge clk);
        #1;
        EX_branch = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        EX_branch = 1'b0; EX_branch_taken = 1'b0; EX_prediction = 1'b0;
        EX_index = '0; EX_pc = '0; EX_imm = '0;
        IF_opcode = OP_BR; IF_pc = 32'h100; IF_imm = 32'h40;
        push_exp("rst_est_a", 0); push_exp("rst_tgt_a", 64'h104);
        push_exp("rst_idx_a", 0); push_exp("rst_bc_a", 0);
        push_exp("rst_mc_a", 0); push_exp("rst_mis_a", 0);
        push_exp("rst_est_b", 0); push_exp("rst_bc_b", 0); push_exp("rst_mc_b", 0);
        @(posedge clk);
        @(negedge clk);
        obs.push_back(64'(est_a)); obs.push_back(64'(tgt_a));
        obs.push_back(64'(idx_a)); obs.push_back(64'(bc_a));
        obs.push_back(64'(mc_a)); obs.push_back(64'(mis_a));
        obs.push_back(64'(est_b)); obs.push_back(64'(bc_b)); obs.push_back(64'(mc_b));
        reset = 1'b1;
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== sb_exp[0]) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", sb_name[0], obs[i], sb_exp[0]);
            end
            void'(sb_name.pop_front()); void'(sb_exp.pop_front());
        end
        obs.delete();
    endtask

    task automatic test_training();
        do_reset();
        IF_opcode = OP_BR; IF_pc = 32'h100; IF_imm = 32'h40;
        ex_cycle(6'd0, 1'b1, 1'b0);                 // 01 -> 10
        push_exp("train_t1_est", 1); push_exp("train_t1_tgt", 64'h140);
        @(negedge clk); obs.push_back(64'(est_a)); obs.push_back(64'(tgt_a));
        ex_cycle(6'd0, 1'b1, 1'b1);                 // 10 -> 11
        ex_cycle(6'd0, 1'b1, 1'b1);                 // 11 saturates
        ex_cycle(6'd0, 1'b0, 1'b1);                 // 11 -> 10
        push_exp("train_sat_hi_est", 1);
        @(negedge clk); obs.push_back(64'(est_a));
        IF_opcode = OP_ALU;
        push_exp("train_nonbr_est", 0); push_exp("train_nonbr_tgt", 64'h104);
        #1; obs.push_back(64'(est_a)); obs.push_back(64'(tgt_a));
        IF_opcode = OP_BR;
        ex_cycle(6'd0, 1'b0, 1'b1);                 // 10 -> 01
        push_exp("train_nt2_est", 0); push_exp("train_nt2_tgt", 64'h104);
        @(negedge clk); obs.push_back(64'(est_a)); obs.push_back(64'(tgt_a));
        ex_cycle(6'd0, 1'b0, 1'b0);                 // 01 -> 00
        ex_cycle(6'd0, 1'b0, 1'b0);                 // 00 saturates
        ex_cycle(6'd0, 1'b1, 1'b0);                 // 00 -> 01
        push_exp("train_sat_lo_est", 0);
        @(negedge clk); obs.push_back(64'(est_a));
        ex_cycle(6'd0, 1'b1, 1'b0);                 // 01 -> 10
        push_exp("train_recover_est", 1);
        @(negedge clk); obs.push_back(64'(est_a));
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== sb_exp[0]) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", sb_name[0], obs[i], sb_exp[0]);
            end
            void'(sb_name.pop_front()); void'(sb_exp.pop_front());
        end
        obs.delete();
    endtask

    task automatic test_mispredict();
        do_reset();
        @(negedge clk);
        EX_branch = 1'b1; EX_index = 6'd10; EX_pc = 32'h200; EX_imm = 32'hFFFF_FFF0;
        EX_prediction = 1'b0; EX_branch_taken = 1'b1;
        push_exp("mp_taken_mis", 1); push_exp("mp_taken_rpc", 64'h1F0);
        #1; obs.push_back(64'(mis_a)); obs.push_back(64'(rpc_a));
        @(negedge clk);
        EX_prediction = 1'b1; EX_branch_taken = 1'b0;
        push_exp("mp_nt_mis", 1); push_exp("mp_nt_rpc", 64'h204);
        #1; obs.push_back(64'(mis_a)); obs.push_back(64'(rpc_a));
        @(negedge clk);
        EX_prediction = 1'b1; EX_branch_taken = 1'b1;
        push_exp("mp_correct_mis", 0); push_exp("mp_correct_rpc", 64'h1F0);
        #1; obs.push_back(64'(mis_a)); obs.push_back(64'(rpc_a));
        @(negedge clk);
        EX_branch = 1'b0; EX_prediction = 1'b0; EX_branch_taken = 1'b1;
        push_exp("mp_nobranch_mis", 0); push_exp("mp_bc", 3); push_exp("mp_mc", 2);
        #1; obs.push_back(64'(mis_a)); obs.push_back(64'(bc_a)); obs.push_back(64'(mc_a));
        @(negedge clk);
        push_exp("mp_hold_bc", 3); push_exp("mp_hold_mc", 2);
        obs.push_back(64'(bc_a)); obs.push_back(64'(mc_a));
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== sb_exp[0]) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", sb_name[0], obs[i], sb_exp[0]);
            end
            void'(sb_name.pop_front()); void'(sb_exp.pop_front());
        end
        obs.delete();
    endtask

    task automatic test_gshare();
        do_reset();
        IF_opcode = OP_BR; IF_imm = 32'h40;
        ex_cycle(6'd1, 1'b1, 1'b0);                 // ghr 0001
        ex_cycle(6'd2, 1'b1, 1'b0);                 // ghr 0011
        ex_cycle(6'd3, 1'b0, 1'b0);                 // ghr 0110
        IF_pc = 32'h0;
        push_exp("gs_idx_b", 6); push_exp("gs_est_b", 0); push_exp("gs_idx_a", 0);
        @(negedge clk); obs.push_back(64'(idx_b)); obs.push_back(64'(est_b)); obs.push_back(64'(idx_a));
        ex_cycle(6'd6, 1'b1, 1'b0);                 // entry 6 -> 10, ghr 1101
        IF_pc = 32'h2C;                              // 11 ^ 13 = 6
        push_exp("gs_e6_idx_b", 6); push_exp("gs_e6_est_b", 1);
        @(negedge clk); obs.push_back(64'(idx_b)); obs.push_back(64'(est_b));
        IF_pc = 32'h34;                              // 13 ^ 13 = 0
        push_exp("gs_e0_idx_b", 0); push_exp("gs_e0_est_b", 0);
        #1; obs.push_back(64'(idx_b)); obs.push_back(64'(est_b));
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== sb_exp[0]) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", sb_name[0], obs[i], sb_exp[0]);
            end
            void'(sb_name.pop_front()); void'(sb_exp.pop_front());
        end
        obs.delete();
    endtask

    task automatic test_collision();
        do_reset();
        IF_opcode = OP_BR; IF_pc = 32'h14; IF_imm = 32'h40;
        @(negedge clk);
        EX_branch = 1'b1; EX_index = 6'd5; EX_branch_taken = 1'b1; EX_prediction = 1'b0;
        push_exp("coll_same_cycle_est", 0);
        #1; obs.push_back(64'(est_a));
        @(posedge clk); #1;
        EX_branch = 1'b0;
        push_exp("coll_next_cycle_est", 1); push_exp("coll_next_cycle_tgt", 64'h54);
        @(negedge clk); obs.push_back(64'(est_a)); obs.push_back(64'(tgt_a));
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== sb_exp[0]) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", sb_name[0], obs[i], sb_exp[0]);
            end
            void'(sb_name.pop_front()); void'(sb_exp.pop_front());
        end
        obs.delete();
    endtask

    task automatic test_reset_wrap_sat();
        do_reset();
        IF_opcode = OP_BR; IF_pc = 32'h0C; IF_imm = 32'hFFFF_FFF0;
        ex_cycle(6'd3, 1'b1, 1'b0);
        ex_cycle(6'd3, 1'b1, 1'b0);                 // entry 3 = 11
        push_exp("mid_trained_est", 1); push_exp("mid_trained_tgt", 64'hFFFF_FFFC);
        @(negedge clk); obs.push_back(64'(est_a)); obs.push_back(64'(tgt_a));
        // reset wins over a simultaneous update
        reset = 1'b0;
        EX_branch = 1'b1; EX_index = 6'd3; EX_branch_taken = 1'b1; EX_prediction = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; EX_branch = 1'b0;
        push_exp("mid_rst_est", 0); push_exp("mid_rst_bc", 0); push_exp("mid_rst_mc", 0);
        @(negedge clk); obs.push_back(64'(est_a)); obs.push_back(64'(bc_a)); obs.push_back(64'(mc_a));
        ex_cycle(6'd3, 1'b1, 1'b1);                 // 01 -> 10 shows reset value was 01
        push_exp("mid_rst_one_taken_est", 1);
        @(negedge clk); obs.push_back(64'(est_a));
        IF_pc = 32'hFFFF_FFFC; IF_imm = 32'h8;
        EX_pc = 32'hFFFF_FFF0; EX_imm = 32'h20; EX_branch_taken = 1'b1;
        push_exp("wrap_if_est", 0); push_exp("wrap_if_tgt", 0); push_exp("wrap_ex_taken_rpc", 64'h10);
        #1; obs.push_back(64'(est_a)); obs.push_back(64'(tgt_a)); obs.push_back(64'(rpc_a));
        EX_pc = 32'hFFFF_FFFC; EX_branch_taken = 1'b0;
        push_exp("wrap_ex_nt_rpc", 0);
        #1; obs.push_back(64'(rpc_a));
        do_reset();
        repeat (14) ex_cycle(6'd9, 1'b1, 1'b0);
        push_exp("stat14_bc_b", 14); push_exp("stat14_mc_b", 14);
        @(negedge clk); obs.push_back(64'(bc_b)); obs.push_back(64'(mc_b));
        repeat (6) ex_cycle(6'd9, 1'b1, 1'b0);
        push_exp("stat20_bc_b", 15); push_exp("stat20_mc_b", 15);
        push_exp("stat20_bc_a", 20); push_exp("stat20_mc_a", 20);
        @(negedge clk);
        obs.push_back(64'(bc_b)); obs.push_back(64'(mc_b));
        obs.push_back(64'(bc_a)); obs.push_back(64'(mc_a));
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== sb_exp[0]) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", sb_name[0], obs[i], sb_exp[0]);
            end
            void'(sb_name.pop_front()); void'(sb_exp.pop_front());
        end
        obs.delete();
    endtask

    initial begin
        reset = 1'b1;
        IF_opcode = OP_BR; IF_pc = '0; IF_imm = '0;
        EX_branch = 1'b0; EX_branch_taken = 1'b0; EX_prediction = 1'b0;
        EX_index = '0; EX_pc = '0; EX_imm = '0;
        test_reset();
        test_training();
        test_mispredict();
        test_gshare();
        test_collision();
        test_reset_wrap_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- PC-indexed branch history table (BHT) of N-bit saturating counters; successor to the single-counter predictor.
- Optional gshare indexing via a global history register (GHR).
- Sits between IF and EX:
  - IF side: combinational prediction and target.
  - EX side: updates the table and GHR, raises the redirect for mispredicts.
- Carries the prediction and table index down the pipeline so the update hits the same entry that made the prediction.

Parameters:
XLEN, 32, datapath/PC width
INDEX_BITS, 6, log2 of table entries (64 entries)
CTR_BITS, 2, saturating counter width (1..4); MSB is the prediction
GHR_BITS, 0, global history length (0 = bimodal; must be <= INDEX_BITS)
STAT_BITS, 32, width of the performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
IF_opcode  input  7  opcode of the fetched instruction
IF_pc  input  XLEN  fetch PC
IF_imm  input  XLEN  branch immediate of the fetched instruction
EX_branch  input  1  EX holds a resolved conditional branch this cycle
EX_branch_taken  input  1  actual outcome
EX_prediction  input  1  branch_estimation carried from IF
EX_index  input  INDEX_BITS  predict_index carried from IF
EX_pc  input  XLEN  PC of the EX branch
EX_imm  input  XLEN  immediate of the EX branch
branch_estimation  output  1  predicted taken
branch_target  output  XLEN  predicted next PC
predict_index  output  INDEX_BITS  table index used for the IF prediction
mispredict  output  1  EX mispredict; flush IF/ID
redirect_pc  output  XLEN  corrected PC when mispredict=1
branch_count  output  STAT_BITS  resolved branches
mispredict_count  output  STAT_BITS  mispredicted branches

Behaviour:
- Index:
  - predict_index = IF_pc[INDEX_BITS+1:2] XOR {zeros, ghr[GHR_BITS-1:0]}.
  - With GHR_BITS=0, no XOR is applied.
- Prediction (combinational):
  - branch_estimation = table[predict_index][CTR_BITS-1] when IF_opcode == OPCODE_BRANCH, else 0.
  - branch_target = IF_pc+IF_imm if branch_estimation=1, else IF_pc+4.
  - All additions are modulo 2^XLEN (wrap, no overflow flag).
- Update, on a rising edge with EX_branch=1:
  - Taken: table[EX_index] increments, saturating at 2^CTR_BITS-1.
  - Not taken: table[EX_index] decrements, saturating at 0.
  - When GHR_BITS>0: ghr <= {ghr[GHR_BITS-2:0], EX_branch_taken}. The GHR is non-speculative and updates only at resolution.
- Mispredict (combinational):
  - mispredict = EX_branch && (EX_prediction != EX_branch_taken).
  - redirect_pc = EX_pc+EX_imm if EX_branch_taken=1, else EX_pc+4.
  - redirect_pc is don't-care when mispredict=0, but must be driven (no X).
- Same-cycle read/write to the same index: the IF read returns the pre-update value. No bypass; the new value is visible on the next cycle.
- EX_branch=0: table, GHR and counters hold. EX_prediction, EX_index and EX_branch_taken are ignored.
- Performance counters:
  - branch_count += 1 per cycle with EX_branch=1.
  - mispredict_count += 1 per cycle with mispredict=1.
  - Both saturate at all-ones; they do not wrap.
- Reset (reset=0 at a rising edge):
  - Every entry is set to weakly-not-taken: 2^(CTR_BITS-1)-1 (01 for CTR_BITS=2; 0 for CTR_BITS=1).
  - ghr=0, branch_count=0, mispredict_count=0.
  - Reset overrides a simultaneous EX update.
  - Reset mid-stream discards all history; the first post-reset IF prediction is not-taken.
- Combinational outputs follow their inputs in the reset cycle. Under reset, branch_estimation reflects the stored table, which is at its reset value after the first reset edge.
- No X propagation: all storage is initialised by reset. Behaviour before the first reset edge is undefined.

Test Plan:
1. Reset default: reset=0 one edge; IF_opcode=BRANCH, IF_pc=0x100, IF_imm=0x40 -> branch_estimation=0, branch_target=0x104, counters=0.
2. Training, bimodal, CTR_BITS=2: resolve index 0 taken twice -> entry 01→10→11; IF at PC 0x100 predicts taken with target 0x140. Then two not-taken -> 11→10→01, predicts not-taken. Extra taken at 11 and extra not-taken at 00 stay saturated.
3. Mispredict: EX_pc=0x200, EX_imm=0xFFFFFFF0, EX_prediction=0, taken=1 -> mispredict=1, redirect_pc=0x1F0, mispredict_count increments. Same with EX_prediction=1, taken=0 -> redirect_pc=0x204.
4. Gshare (GHR_BITS=4): resolve taken, taken, not-taken -> ghr=0b0110; IF_pc=0x0 gives predict_index=6. Update via EX_index=6 alters only entry 6; entry 0 is unchanged.
5. Same-index collision: EX updates index 5 from 01→10 in the cycle IF reads index 5 -> IF sees not-taken that cycle and taken the next cycle.
6. Reset mid-operation plus wrap/saturation:
   - Train entry 3 to 11, then pulse reset=0 with EX_branch=1 -> entry 3=01, stats=0.
   - IF_pc=0xFFFFFFFC, not-taken -> branch_target=0x00000000.
   - STAT_BITS=4 with 20 branches -> branch_count=15.
